piece_motion_ctrl: RTL and testbench

Parametrised successor to the fixed-size falling-block logic in the Tetris VGA top level. Owns the active piece's position in grid-cell units, gravity timing, soft/hard drop, button synchronisation with auto-repeat, and lock/respawn sequencing. Emits a registered per-pixel "inside active piece" flag that the colour mux uses to overlay the piece on the background image. Sits between the button inputs and the VGA colour path. Runs on the 100 MHz system clock; gravity and repeat rates are set by divider parameters.

---
 rtl/tetris_pkg.sv | 14 +
 rtl/piece_motion_ctrl_if.sv | 19 +
 rtl/piece_motion_ctrl_btn_repeat.sv | 37 +++
 rtl/piece_motion_ctrl.sv | 106 ++++++++++
 tb/tb_piece_motion_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece FSM encoding, video geometry and playfield defaults
package tetris_pkg;
  typedef enum logic [1:0] {SPAWN = 2'd0, FALL = 2'd1, LAND = 2'd2, LOCK = 2'd3} state_t;
  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int DEF_CELL_PX = 24;
  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;
  localparam int DEF_PLAY_X0 = 200;
  localparam int DEF_PLAY_Y0 = 0;
  localparam int DEF_PIECE_W = 2;
  localparam int DEF_PIECE_H = 2;
  localparam int DEF_SPAWN_COL = 4;
endpackage

// File: rtl/piece_motion_ctrl_if.sv
// piece_motion_ctrl_if: button/pixel inputs and piece status outputs of the motion controller
interface piece_motion_ctrl_if
  import tetris_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
);
  logic left, right, down, up;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic in_block, locked;
  logic [$clog2(COLS)-1:0] block_col;
  logic [$clog2(ROWS)-1:0] block_row;
  logic [1:0] fsm_state;
  modport master (output left, right, down, up, pix_x, pix_y,
                  input in_block, block_col, block_row, locked, fsm_state);
  modport slave (input left, right, down, up, pix_x, pix_y,
                 output in_block, block_col, block_row, locked, fsm_state);
endinterface

// File: rtl/piece_motion_ctrl_btn_repeat.sv
// btn_repeat: 2-flop synchroniser, rising-edge detect and delay-then-rate auto-repeat
module btn_repeat #(
  parameter int REPEAT_DELAY = 20000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic hold_i,
  output logic lvl_o,
  output logic req_o
);
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [2:0] sh_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rate_q, rate_d, rise, fire;
  // rate_q marks that the first (delay) repeat has already fired
  always_comb begin
    rise = sh_q[1] & ~sh_q[2];
    fire = sh_q[1] & ~rise & ~hold_i &
           (cnt_q == (rate_q ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1)));
    cnt_d = (~sh_q[1] | rise | hold_i | fire) ? '0 : cnt_q + CW'(1);
    rate_d = (~sh_q[1] | rise) ? 1'b0 : (rate_q | fire);
  end
  assign lvl_o = sh_q[1];
  assign req_o = ~hold_i & (rise | fire);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sh_q <= '0;
      cnt_q <= '0;
      rate_q <= 1'b0;
    end else begin
      sh_q <= {sh_q[1:0], btn_i};
      cnt_q <= cnt_d;
      rate_q <= rate_d;
    end
endmodule

// File: rtl/piece_motion_ctrl.sv
// piece_motion_ctrl: active-piece position, gravity, drops, auto-repeat and lock/respawn sequencing
module piece_motion_ctrl
  import tetris_pkg::*;
#(
  parameter int CELL_PX = DEF_CELL_PX,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int PLAY_X0 = DEF_PLAY_X0,
  parameter int PLAY_Y0 = DEF_PLAY_Y0,
  parameter int PIECE_W = DEF_PIECE_W,
  parameter int PIECE_H = DEF_PIECE_H,
  parameter int SPAWN_COL = DEF_SPAWN_COL,
  parameter int GRAVITY_DIV = 1000000,
  parameter int SOFT_DIV = 100000,
  parameter int REPEAT_DELAY = 20000000,
  parameter int REPEAT_RATE = 5000000,
  parameter int LOCK_CYCLES = 25000000
) (
  input logic clk,
  input logic reset,
  piece_motion_ctrl_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2((GRAVITY_DIV > SOFT_DIV ? GRAVITY_DIV : SOFT_DIV) + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] grav_q, grav_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [2:0] up_q;
  logic [1:0] dn_q;
  logic inb_q, inb_d;
  logic l_lvl, r_lvl, l_req, r_req, up_rise, step, mv;
  logic [10:0] x_lo, x_hi, y_lo, y_hi;
  // holding both directions cancels both: each repeater is frozen by the pair
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
    .clk(clk), .reset(reset), .btn_i(bus.left), .hold_i(l_lvl & r_lvl), .lvl_o(l_lvl), .req_o(l_req)
  );
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
    .clk(clk), .reset(reset), .btn_i(bus.right), .hold_i(l_lvl & r_lvl), .lvl_o(r_lvl), .req_o(r_req)
  );
  always_comb begin
    up_rise = up_q[1] & ~up_q[2];
    step = grav_q >= (dn_q[1] ? GW'(SOFT_DIV - 1) : GW'(GRAVITY_DIV - 1));
    mv = state_q == FALL || state_q == LAND;
    x_lo = 11'(PLAY_X0 + int'(col_q) * CELL_PX);
    x_hi = x_lo + 11'(PIECE_W * CELL_PX);
    y_lo = 11'(PLAY_Y0 + int'(row_q) * CELL_PX);
    y_hi = y_lo + 11'(PIECE_H * CELL_PX);
    inb_d = {1'b0, bus.pix_x} >= x_lo && {1'b0, bus.pix_x} < x_hi &&
            {2'b0, bus.pix_y} >= y_lo && {2'b0, bus.pix_y} < y_hi;
    state_d = state_q;
    col_d = mv && l_req && col_q != '0 ? col_q - CW'(1) :
            mv && r_req && int'(col_q) + PIECE_W < COLS ? col_q + CW'(1) : col_q;
    row_d = row_q;
    grav_d = '0;
    lock_d = '0;
    case (state_q)
      SPAWN: state_d = FALL;
      FALL: begin
        grav_d = step ? '0 : grav_q + GW'(1);
        if (up_rise) begin
          row_d = RW'(ROWS - PIECE_H);
          state_d = LOCK;
        end else if (step && int'(row_q) + PIECE_H < ROWS) row_d = row_q + RW'(1);
        else if (step) state_d = LAND;
      end
      LAND: begin
        lock_d = lock_q + LW'(1);
        if (up_rise || lock_q == LW'(LOCK_CYCLES - 1)) state_d = LOCK;
      end
      default: state_d = SPAWN;
    endcase
    if (state_q == SPAWN || state_q == LOCK) begin
      col_d = CW'(SPAWN_COL);
      row_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= SPAWN;
      col_q <= CW'(SPAWN_COL);
      row_q <= '0;
      grav_q <= '0;
      lock_q <= '0;
      up_q <= '0;
      dn_q <= '0;
      inb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      grav_q <= grav_d;
      lock_q <= lock_d;
      up_q <= {up_q[1:0], bus.up};
      dn_q <= {dn_q[0], bus.down};
      inb_q <= inb_d;
    end
  assign bus.in_block = inb_q;
  assign bus.block_col = col_q;
  assign bus.block_row = row_q;
  assign bus.locked = state_q == LOCK;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_piece_motion_ctrl.sv
// tb_piece_motion_ctrl: directed and random stimulus against a cycle-level reference model
module tb_piece_motion_ctrl;
  localparam int CP = 24, CO = 6, RO = 4, X0 = 200, Y0 = 0, PW = 2, PH = 2, SC = 2;
  localparam int GD = 8, SD = 2, RD = 10, RR = 4, LC = 6;
  logic clk = 1'b0;
  logic reset = 1'b0;
  piece_motion_ctrl_if #(.COLS(CO), .ROWS(RO)) bus ();
  piece_motion_ctrl #(
    .CELL_PX(CP), .COLS(CO), .ROWS(RO), .PLAY_X0(X0), .PLAY_Y0(Y0), .PIECE_W(PW), .PIECE_H(PH),
    .SPAWN_COL(SC), .GRAVITY_DIV(GD), .SOFT_DIV(SD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .LOCK_CYCLES(LC)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit l, r, dn, u, rndp;
  int px, py;
  logic [3:0] hist[$];
  int m_mode, m_col, m_row, m_grav, m_land, age_l, age_r, m_inb;

  function automatic void model_reset();
    m_mode = 0; m_col = SC; m_row = 0; m_grav = 0; m_land = 0;
    age_l = -1; age_r = -1; m_inb = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(4'h0);
  endfunction

  function automatic bit fires(int age);
    return age == 0 || (age >= RD && (age - RD) % RR == 0);
  endfunction

  function automatic void model_edge();
    bit lv, rv, dv, ur, req_l, req_r;
    hist.push_front({u, dn, r, l});
    void'(hist.pop_back());
    lv = hist[2][0]; rv = hist[2][1]; dv = hist[2][2];
    ur = hist[2][3] && !hist[3][3];
    age_l = lv ? age_l + 1 : -1;
    age_r = rv ? age_r + 1 : -1;
    req_l = lv && !rv && fires(age_l);
    req_r = rv && !lv && fires(age_r);
    m_inb = int'(px >= X0 + m_col * CP && px < X0 + (m_col + PW) * CP &&
                  py >= Y0 + m_row * CP && py < Y0 + (m_row + PH) * CP);
    if (m_mode == 1 || m_mode == 2) begin
      if (req_l && m_col > 0) m_col--;
      else if (req_r && m_col + PW < CO) m_col++;
    end
    case (m_mode)
      0: begin m_col = SC; m_row = 0; m_grav = 0; m_mode = 1; end
      1: begin
        if (ur) begin m_row = RO - PH; m_mode = 3; end
        else if (m_grav >= (dv ? SD - 1 : GD - 1)) begin
          m_grav = 0;
          if (m_row + PH < RO) m_row++;
          else begin m_mode = 2; m_land = 0; end
        end else m_grav++;
      end
      2: if (ur || m_land == LC - 1) m_mode = 3; else m_land++;
      default: begin m_col = SC; m_row = 0; m_mode = 0; end
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rndp) begin px = $urandom_range(180, 400); py = $urandom_range(0, 120); end
    bus.left = l; bus.right = r; bus.down = dn; bus.up = u;
    bus.pix_x = 10'(px); bus.pix_y = 9'(py);
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    #1;
    chk("col", 32'(bus.block_col), m_col);
    chk("row", 32'(bus.block_row), m_row);
    chk("state", 32'(bus.fsm_state), m_mode);
    chk("locked", 32'(bus.locked), 32'(m_mode == 3));
    chk("in_block", 32'(bus.in_block), m_inb);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    l = 0; r = 0; dn = 0; u = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    l = 0; r = 0; dn = 0; u = 0; rndp = 1; px = 0; py = 0;
    model_reset();
    do_reset();
    // gravity, landing and lock timing with no input
    run(9); chk("grav_row1", 32'(bus.block_row), 1);
    run(8); chk("grav_row2", 32'(bus.block_row), 2);
    run(8); chk("land_enter", 32'(bus.fsm_state), 2);
    run(6); chk("lock_pulse", 32'(bus.locked), 1);
    run(1); chk("respawn_state", 32'(bus.fsm_state), 0);
    chk("respawn_col", 32'(bus.block_col), 2);
    chk("respawn_row", 32'(bus.block_row), 0);
    // single right pulse: three-cycle latency
    do_reset(); run(1);
    r = 1; tick(); r = 0;
    tick(); chk("right_lat2", 32'(bus.block_col), 2);
    tick(); chk("right_lat3", 32'(bus.block_col), 3);
    // held right saturates at the wall
    do_reset(); run(1);
    r = 1; run(28); r = 0;
    chk("right_sat", 32'(bus.block_col), 4);
    // held left: first move, delayed repeat, then blocked at wall
    do_reset(); run(1);
    l = 1; run(3); chk("left_first", 32'(bus.block_col), 1);
    run(9); chk("left_pre_rep", 32'(bus.block_col), 1);
    run(1); chk("left_rep", 32'(bus.block_col), 0);
    run(8); chk("left_wall", 32'(bus.block_col), 0);
    l = 0;
    // both directions cancel
    do_reset(); run(1);
    l = 1; r = 1; run(20); chk("both_hold", 32'(bus.block_col), 2);
    l = 0; r = 0; run(3); chk("both_release", 32'(bus.block_col), 2);
    // soft drop steps every two cycles
    do_reset(); run(1);
    dn = 1; run(3); chk("soft_row1", 32'(bus.block_row), 1);
    run(1); chk("soft_row1b", 32'(bus.block_row), 1);
    run(1); chk("soft_row2", 32'(bus.block_row), 2);
    dn = 0;
    // hard drop from row 0
    do_reset(); run(1);
    u = 1; tick(); u = 0;
    tick(); chk("hard_pre", 32'(bus.block_row), 0);
    tick(); chk("hard_row", 32'(bus.block_row), 2);
    chk("hard_lock", 32'(bus.locked), 1);
    tick(); chk("hard_spawn", 32'(bus.fsm_state), 0);
    // asynchronous reset mid-LAND, then in_block bounds
    do_reset(); run(27); chk("pre_async_land", 32'(bus.fsm_state), 2);
    #2; reset = 1'b0; model_reset();
    #1;
    chk("async_state", 32'(bus.fsm_state), 0);
    chk("async_col", 32'(bus.block_col), 2);
    chk("async_row", 32'(bus.block_row), 0);
    chk("async_locked", 32'(bus.locked), 0);
    chk("async_inb", 32'(bus.in_block), 0);
    rndp = 0; px = 248; py = 0;
    tick(); reset = 1'b1;
    tick(); chk("inb_inside", 32'(bus.in_block), 1);
    px = 296; tick(); chk("inb_edge_out", 32'(bus.in_block), 0);
    px = 295; tick(); chk("inb_edge_in", 32'(bus.in_block), 1);
    rndp = 1;
    // random operation sequence
    do_reset();
    for (int k = 0; k < 60; k++) begin
      int op, n;
      op = $urandom_range(0, 5);
      n = $urandom_range(1, 25);
      case (op)
        1: l = 1;
        2: r = 1;
        3: dn = 1;
        4: begin u = 1; n = 1; end
        5: begin l = 1; r = 1; end
        default: ;
      endcase
      run(n);
      l = 0; r = 0; dn = 0; u = 0;
      run($urandom_range(1, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
